mem_port_arbiter: RTL and testbench

- Shares one unified 32-bit memory port between the pipelined core's instruction-fetch requester and its load/store requester.
- Serialises accesses with one transaction outstanding at a time and routes each response back to the requester that issued it.
- Data accesses have priority, so the pipeline drains and cannot deadlock. A starvation counter guarantees fetch forward progress.
- Sits between pipelined_core (pc_out / DataADDR / WriteData / mem_read_req / mem_write_req) and the memory model or bus bridge.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and unified-memory handshakes around mem_port_arbiter.
// slave = the arbiter itself, master = the core plus memory environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  logic              err_rvalid;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, err_rvalid
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, err_rvalid
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store traffic onto one 32-bit memory port,
// data first with a starvation guard for fetch. Define MEM_ARB_TIMEOUT_EN for the abort timer.
module mem_port_arbiter #(
  parameter int          ADDR_W         = 32,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  if (ADDR_W < 1 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mem_port_arbiter: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] starve_cnt;
  logic       starve_full;
  logic       owner;
  logic       grant_if;
  logic       grant_d;
  logic       done;

  assign starve_full = (starve_cnt == 4'(STARVE_LIMIT));

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    done      = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_hit   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!reset) begin
          if (bus.d_req && !(bus.if_req && starve_full)) begin
            grant_d = 1'b1;
          end else if (bus.if_req) begin
            grant_if = 1'b1;
          end
          if (grant_d || grant_if) begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.mem_gnt && bus.mem_rvalid) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (bus.mem_gnt) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef MEM_ARB_TIMEOUT_EN
    // A response arriving on the final cycle still counts as completion.
    if (state != IDLE && !done && tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      tmo_hit   = 1'b1;
      state_nxt = IDLE;
    end
`endif
  end

  assign bus.if_gnt  = grant_if;
  assign bus.d_gnt   = grant_d;
  assign bus.mem_req = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt    <= '0;
      owner         <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rvalid  <= 1'b0;
      bus.d_rdata   <= '0;
    end else begin
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;

      if (grant_d) begin
        owner         <= 1'b1;
        bus.mem_we    <= bus.d_we;
        bus.mem_addr  <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
        bus.mem_be    <= bus.d_be;
      end else if (grant_if) begin
        owner         <= 1'b0;
        bus.mem_we    <= 1'b0;
        bus.mem_addr  <= bus.if_addr;
        bus.mem_wdata <= '0;
        bus.mem_be    <= '1;
      end

      if (grant_if) begin
        starve_cnt <= '0;
      end else if (grant_d && bus.if_req && !starve_full) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      if (done) begin
        if (owner) begin
          bus.d_rvalid <= 1'b1;
          bus.d_rdata  <= bus.mem_we ? '0 : bus.mem_rdata;
        end else begin
          bus.if_rvalid <= 1'b1;
          bus.if_rdata  <= bus.mem_rdata;
        end
      end
`ifdef MEM_ARB_TIMEOUT_EN
      else if (tmo_hit) begin
        if (owner) begin
          bus.d_rvalid <= 1'b1;
          bus.d_rdata  <= '0;
        end else begin
          bus.if_rvalid <= 1'b1;
          bus.if_rdata  <= '0;
        end
      end
`endif
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt        <= '0;
      bus.err_rvalid <= 1'b0;
    end else begin
      bus.err_rvalid <= tmo_hit;
      if (grant_if || grant_d) begin
        tmo_cnt <= '0;
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end
`else
  assign bus.err_rvalid = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: requesters and memory are driven with $urandom,
// every cycle is compared against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int unsigned STARVE = 4;
  localparam int unsigned TMO    = 8;
  localparam int unsigned PHASE_CYCLES = 500;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W        (32),
    .STARVE_LIMIT  (STARVE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: one outstanding transaction record plus the response due on the next cycle.
  bit          busy, taken, stall, rec_owner, rec_we;
  logic [31:0] rec_addr, rec_wdata;
  logic [3:0]  rec_be;
  int unsigned age, starve;
  bit          pend_if, pend_d, pend_err;
  logic [31:0] pend_data, last_if, last_d;
  bit          was_reset, if_granted, d_granted;

  // Stimulus knobs (percent, reset in per-mille)
  int unsigned p_if, p_d, p_gnt, p_rv, p_rst, p_wd;

  task automatic drive_cycle(input bit force_rst);
    reset = force_rst || ($urandom_range(999) < p_rst);
    if (!bus.if_req || if_granted || ($urandom_range(99) < p_wd)) begin
      bus.if_req  = ($urandom_range(99) < p_if);
      bus.if_addr = {$urandom_range(32'h3FFF_FFFF), 2'b00};
    end
    if (!bus.d_req || d_granted || ($urandom_range(99) < p_wd)) begin
      bus.d_req   = ($urandom_range(99) < p_d);
      bus.d_we    = $urandom_range(1);
      bus.d_addr  = $urandom;
      bus.d_wdata = $urandom;
      bus.d_be    = 4'($urandom_range(15));
    end
    bus.mem_rdata  = $urandom;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    if (busy && !taken) begin
      bus.mem_gnt    = ($urandom_range(99) < p_gnt);
      bus.mem_rvalid = bus.mem_gnt && !stall && ($urandom_range(99) < p_rv);
    end else if (busy) begin
      bus.mem_rvalid = !stall && ($urandom_range(99) < p_rv);
    end else begin
      bus.mem_rvalid = ($urandom_range(99) < 10);
    end
  endtask

  task automatic check_and_step();
    bit win_d, win_if, free, complete;
    free   = !reset && !busy;
    win_d  = free && bus.d_req && !(bus.if_req && starve == STARVE);
    win_if = free && !win_d && bus.if_req;

    check("if_gnt", 32'(bus.if_gnt), 32'(win_if));
    check("d_gnt", 32'(bus.d_gnt), 32'(win_d));
    check("mem_req", 32'(bus.mem_req), 32'(busy && !taken));
    if (busy && !taken) begin
      check("mem_we", 32'(bus.mem_we), 32'(rec_we));
      check("mem_addr", bus.mem_addr, rec_addr);
      check("mem_be", 32'(bus.mem_be), 32'(rec_be));
      if (rec_owner) check("mem_wdata", bus.mem_wdata, rec_wdata);
    end
    if (was_reset) begin
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_mem_fields", {27'h0, bus.mem_we, bus.mem_be}, 32'h0);
      check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    end
    check("if_rvalid", 32'(bus.if_rvalid), 32'(pend_if));
    check("d_rvalid", 32'(bus.d_rvalid), 32'(pend_d));
    check("err_rvalid", 32'(bus.err_rvalid), 32'(pend_err));
    if (pend_if) last_if = pend_data;
    if (pend_d) last_d = pend_data;
    check("if_rdata", bus.if_rdata, last_if);
    check("d_rdata", bus.d_rdata, last_d);

    pend_if = 1'b0; pend_d = 1'b0; pend_err = 1'b0;
    if_granted = win_if;
    d_granted  = win_d;
    if (reset) begin
      busy = 1'b0; starve = 0; last_if = '0; last_d = '0; was_reset = 1'b1;
    end else begin
      was_reset = 1'b0;
      if (busy) begin
        complete = taken ? bus.mem_rvalid : (bus.mem_gnt && bus.mem_rvalid);
        if (complete) begin
          busy      = 1'b0;
          pend_data = rec_we ? 32'h0 : bus.mem_rdata;
          pend_d    = rec_owner;
          pend_if   = !rec_owner;
        end else begin
          if (bus.mem_gnt) taken = 1'b1;
          age++;
`ifdef MEM_ARB_TIMEOUT_EN
          if (age == TMO) begin
            busy      = 1'b0;
            pend_data = 32'h0;
            pend_d    = rec_owner;
            pend_if   = !rec_owner;
            pend_err  = 1'b1;
          end
`endif
        end
      end else if (win_d || win_if) begin
        busy = 1'b1; taken = 1'b0; age = 0;
`ifdef MEM_ARB_TIMEOUT_EN
        stall = ($urandom_range(5) == 0);
`else
        stall = 1'b0;
`endif
        rec_owner = win_d;
        rec_we    = win_d ? bus.d_we : 1'b0;
        rec_addr  = win_d ? bus.d_addr : bus.if_addr;
        rec_wdata = bus.d_wdata;
        rec_be    = win_d ? bus.d_be : 4'hF;
        if (win_if) starve = 0;
        else if (bus.if_req && starve < STARVE) starve++;
      end
    end
  endtask

  task automatic run_phase(input int unsigned n_cycles);
    for (int unsigned c = 0; c < n_cycles; c++) begin
      @(posedge clk);
      #1;
      drive_cycle(1'b0);
      @(negedge clk);
      check_and_step();
    end
  endtask

  initial begin
    busy = 0; taken = 0; stall = 0; rec_owner = 0; rec_we = 0;
    rec_addr = '0; rec_wdata = '0; rec_be = '0; age = 0; starve = 0;
    pend_if = 0; pend_d = 0; pend_err = 0; pend_data = '0;
    last_if = '0; last_d = '0; was_reset = 0; if_granted = 0; d_granted = 0;
    reset = 1'b1;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    p_if = 50; p_d = 50; p_gnt = 60; p_rv = 50; p_rst = 0; p_wd = 3;

    for (int unsigned c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      drive_cycle(1'b1);
      @(negedge clk);
      check_and_step();
    end

    p_rst = 4;
    run_phase(PHASE_CYCLES);
    p_if = 100; p_d = 100; p_wd = 0; p_gnt = 80; p_rv = 70;
    run_phase(PHASE_CYCLES);
    p_if = 60; p_d = 60; p_wd = 3; p_gnt = 8; p_rv = 20; p_rst = 6;
    run_phase(PHASE_CYCLES);
    p_if = 30; p_d = 80; p_gnt = 100; p_rv = 100; p_rst = 2;
    run_phase(PHASE_CYCLES);
    p_if = 40; p_d = 40; p_gnt = 50; p_rv = 30; p_rst = 10; p_wd = 10;
    run_phase(PHASE_CYCLES);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
